// File: rtl/scan_seq_arb.sv
// scan_seq_arb: runs enabled area-scan engines in index order and routes one engine's buses via a registered one-hot grant.
// Optional build macro SCAN_SEQ_WDOG_EN adds the per-area watchdog (error code 2).
module scan_seq_arb #(
  parameter int unsigned N_AREA      = 3,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned FRAM_W      = 43,
  parameter int unsigned CUDB_W      = 24,
  parameter int unsigned CDDB_W      = 24,
  parameter int unsigned TO_W        = 20,
  parameter int unsigned TIMEOUT_CYC = 32'h000F_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start_con,
  input  logic [11:0]              im_base_addr,
  input  logic [N_AREA-1:0]        im_area_en,
  input  logic                     i_stop_on_err,
  output logic                     o_busy,
  output logic                     o_done_con,
  output logic                     o_error_con,
  output logic [1:0]               om_err_code,
  output logic [IDX_W-1:0]         om_err_area,
  output logic [N_AREA-1:0]        om_start,
  output logic [11:0]              om_base_addr,
  input  logic [N_AREA-1:0]        i_done,
  input  logic [N_AREA-1:0]        i_error,
  input  logic [N_AREA*FRAM_W-1:0] im_fram_req,
  output logic [FRAM_W-1:0]        om_fram_bus,
  input  logic [N_AREA*CUDB_W-1:0] im_cudb_req,
  output logic [CUDB_W-1:0]        om_cudb_bus,
  input  logic [N_AREA*CDDB_W-1:0] im_cddb_req,
  output logic [CDDB_W-1:0]        om_cddb_bus,
  output logic [N_AREA-1:0]        om_grant
);

  localparam int unsigned BASE_W   = 12;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_AREA - 1);
  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_AREA = 2'd1;

  if (N_AREA < 2 || N_AREA > 8 || (N_AREA - 1) >= (32'd1 << IDX_W) ||
      TO_W < 2 || TO_W > 31 || TIMEOUT_CYC < 2 || TIMEOUT_CYC >= (32'd1 << TO_W)) begin : g_bad_cfg
    $error("scan_seq_arb: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_AREA-1:0]   grant_q, grant_d;
  logic [N_AREA-1:0]   start_q, start_d;
  logic [N_AREA-1:0]   en_q, en_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                stop_q, stop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          code_q, code_d;
  logic [IDX_W-1:0]    area_q, area_d;

  logic                sel_found_c;
  logic [IDX_W-1:0]    sel_idx_c;
  logic                done_hit_c;
  logic                err_hit_c;

`ifdef SCAN_SEQ_WDOG_EN
  localparam logic [1:0]      CODE_WDOG = 2'd2;
  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wdog_q, wdog_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`endif

  // Lowest enabled area at or above the current index.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int k = int'(N_AREA) - 1; k >= 0; k--) begin
      if (en_q[k] && (IDX_W'(k) >= idx_q)) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(k);
      end
    end
  end

  // The grant is one-hot on idx, so masking with it observes only the active engine.
  assign done_hit_c = |(i_done & grant_q);
  assign err_hit_c  = |(i_error & grant_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      grant_q <= '0;
      start_q <= '0;
      en_q    <= '0;
      base_q  <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= CODE_NONE;
      area_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      start_q <= start_d;
      en_q    <= en_d;
      base_q  <= base_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      area_q  <= area_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    start_d = '0;
    en_d    = en_q;
    base_d  = base_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    area_d  = area_q;
`ifdef SCAN_SEQ_WDOG_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_start_con) begin
          base_d  = im_base_addr;
          en_d    = im_area_en;
          stop_d  = i_stop_on_err;
          code_d  = CODE_NONE;
          area_d  = '0;
          error_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_found_c) begin
          idx_d   = sel_idx_c;
          grant_d = N_AREA'(1) << sel_idx_c;
          start_d = N_AREA'(1) << sel_idx_c;
          state_d = S_START;
        end else begin
          state_d = S_DONE;
        end
      end
      S_START: begin
`ifdef SCAN_SEQ_WDOG_EN
        wdog_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An error arriving with done still counts; only the first error is kept.
        if (done_hit_c || err_hit_c) begin
          if (err_hit_c && (code_q == CODE_NONE)) begin
            code_d = CODE_AREA;
            area_d = idx_q;
          end
          state_d = S_NEXT;
        end
`ifdef SCAN_SEQ_WDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          if (code_q == CODE_NONE) begin
            code_d = CODE_WDOG;
            area_d = idx_q;
          end
          state_d = S_NEXT;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_NEXT: begin
        grant_d = '0;
        if ((code_q != CODE_NONE) && stop_q) begin
          state_d = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SELECT;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        error_d = (code_q != CODE_NONE);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // AND-OR mux on the registered one-hot grant; all zero when nothing is granted.
  always_comb begin
    om_fram_bus = '0;
    om_cudb_bus = '0;
    om_cddb_bus = '0;
    for (int unsigned k = 0; k < N_AREA; k++) begin
      if (grant_q[k]) begin
        om_fram_bus = om_fram_bus | im_fram_req[k*FRAM_W +: FRAM_W];
        om_cudb_bus = om_cudb_bus | im_cudb_req[k*CUDB_W +: CUDB_W];
        om_cddb_bus = om_cddb_bus | im_cddb_req[k*CDDB_W +: CDDB_W];
      end
    end
  end

  assign o_busy       = busy_q;
  assign o_done_con   = done_q;
  assign o_error_con  = error_q;
  assign om_err_code  = code_q;
  assign om_err_area  = area_q;
  assign om_start     = start_q;
  assign om_base_addr = base_q;
  assign om_grant     = grant_q;

endmodule

// File: tb/tb_scan_seq_arb.sv
// Scoreboard bench for scan_seq_arb: expected starts/completions queued at stimulus, checked as the DUT produces them.
module tb_scan_seq_arb;

  localparam int unsigned N      = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned FRAM_W = 43;
  localparam int unsigned CUDB_W = 24;
  localparam int unsigned CDDB_W = 24;
  localparam int unsigned TO_W   = 20;
  localparam int unsigned TMO    = 16;
  localparam int          DLY    = 10;

  typedef struct packed {
    logic        err;
    logic [1:0]  code;
    logic [2:0]  area;
    logic [15:0] lat;
  } exp_done_t;

  logic                clk;
  logic                rst;
  logic                i_start_con;
  logic [11:0]         im_base_addr;
  logic [N-1:0]        im_area_en;
  logic                i_stop_on_err;
  logic                o_busy;
  logic                o_done_con;
  logic                o_error_con;
  logic [1:0]          om_err_code;
  logic [IDX_W-1:0]    om_err_area;
  logic [N-1:0]        om_start;
  logic [11:0]         om_base_addr;
  logic [N-1:0]        i_done;
  logic [N-1:0]        i_error;
  logic [N*FRAM_W-1:0] im_fram_req;
  logic [FRAM_W-1:0]   om_fram_bus;
  logic [N*CUDB_W-1:0] im_cudb_req;
  logic [CUDB_W-1:0]   om_cudb_bus;
  logic [N*CDDB_W-1:0] im_cddb_req;
  logic [CDDB_W-1:0]   om_cddb_bus;
  logic [N-1:0]        om_grant;

  logic [FRAM_W-1:0] fram_d [N];
  logic [CUDB_W-1:0] cudb_d [N];
  logic [CDDB_W-1:0] cddb_d [N];

  logic [N-1:0] err_cfg;
  logic [N-1:0] hang_cfg;

  int        n_vec;
  int        n_err;
  int        cyc;
  int        start_cyc;
  logic      done_seen;
  int        exp_start_q[$];
  exp_done_t exp_done_q[$];

  scan_seq_arb #(
    .N_AREA(N), .IDX_W(IDX_W), .FRAM_W(FRAM_W), .CUDB_W(CUDB_W),
    .CDDB_W(CDDB_W), .TO_W(TO_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .i_start_con(i_start_con), .im_base_addr(im_base_addr),
    .im_area_en(im_area_en), .i_stop_on_err(i_stop_on_err), .o_busy(o_busy),
    .o_done_con(o_done_con), .o_error_con(o_error_con), .om_err_code(om_err_code),
    .om_err_area(om_err_area), .om_start(om_start), .om_base_addr(om_base_addr),
    .i_done(i_done), .i_error(i_error), .im_fram_req(im_fram_req),
    .om_fram_bus(om_fram_bus), .im_cudb_req(im_cudb_req), .om_cudb_bus(om_cudb_bus),
    .im_cddb_req(im_cddb_req), .om_cddb_bus(om_cddb_bus), .om_grant(om_grant)
  );

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign im_fram_req[k*FRAM_W +: FRAM_W] = fram_d[k];
    assign im_cudb_req[k*CUDB_W +: CUDB_W] = cudb_d[k];
    assign im_cddb_req[k*CDDB_W +: CDDB_W] = cddb_d[k];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fresh request data every cycle, changed well away from both clock edges.
  initial begin : data_gen
    forever begin
      for (int k = 0; k < N; k++) begin
        fram_d[k] = FRAM_W'({$urandom(), $urandom()});
        cudb_d[k] = CUDB_W'($urandom());
        cddb_d[k] = CDDB_W'($urandom());
      end
      @(posedge clk);
      #2;
    end
  end

  // Engine models: done DLY cycles after start, optional error with done, optional hang.
  // Area 0 also strobes stray done/error bits on other lanes mid-run.
  initial begin : engines
    int   rem [N];
    logic [N-1:0] active;
    active  = '0;
    i_done  = '0;
    i_error = '0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    forever begin
      @(negedge clk);
      i_done  = '0;
      i_error = '0;
      if (!rst) begin
        active = '0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (active[k]) begin
            rem[k] = rem[k] - 1;
            if (k == 0 && rem[k] == 5) begin
              i_done[1]  = 1'b1;
              i_error[2] = 1'b1;
            end
            if (rem[k] == 0) begin
              i_done[k]  = 1'b1;
              i_error[k] = err_cfg[k];
              active[k]  = 1'b0;
            end
          end
        end
        for (int k = 0; k < N; k++) begin
          if (om_start[k]) begin
            active[k] = !hang_cfg[k];
            rem[k]    = DLY;
          end
        end
      end
    end
  end

  // Output monitor: start order, grant/bus ownership and completion results.
  initial begin : monitor
    logic [N-1:0] mgrant;
    int           mg_cnt;
    int           mg_k;
    int           k;
    exp_done_t    e;
    mgrant = '0;
    mg_cnt = 0;
    mg_k   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mg_cnt = 0;
      end else begin
        if (om_start != '0) begin
          if (exp_start_q.size() == 0) begin
            chk("start_unexpected", 64'(om_start), 64'd0);
          end else begin
            k = exp_start_q.pop_front();
            chk("start_onehot", 64'(om_start), 64'(N'(1) << k));
            mgrant = N'(1) << k;
            mg_k   = k;
            mg_cnt = hang_cfg[k] ? int'(TMO) + 2 : DLY + 2;
          end
        end
        chk("grant", 64'(om_grant), 64'(mg_cnt > 0 ? mgrant : N'(0)));
        chk("fram_bus", 64'(om_fram_bus), 64'(mg_cnt > 0 ? fram_d[mg_k] : FRAM_W'(0)));
        chk("cudb_bus", 64'(om_cudb_bus), 64'(mg_cnt > 0 ? cudb_d[mg_k] : CUDB_W'(0)));
        chk("cddb_bus", 64'(om_cddb_bus), 64'(mg_cnt > 0 ? cddb_d[mg_k] : CDDB_W'(0)));
        if (mg_cnt > 0) mg_cnt = mg_cnt - 1;
        if (o_done_con) begin
          if (exp_done_q.size() == 0) begin
            chk("done_unexpected", 64'(o_done_con), 64'd0);
          end else begin
            e = exp_done_q.pop_front();
            chk("error_con", 64'(o_error_con), 64'(e.err));
            chk("err_code", 64'(om_err_code), 64'(e.code));
            chk("err_area", 64'(om_err_area), 64'(e.area));
            chk("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
          end
          done_seen = 1'b1;
        end
      end
    end
  end

  task automatic run_seq(input logic [N-1:0] mask, input logic stop, input logic [11:0] base,
                         input logic [N-1:0] started, input logic err, input logic [1:0] code,
                         input logic [2:0] area, input int lat);
    int budget;
    for (int k = 0; k < N; k++) if (started[k]) exp_start_q.push_back(k);
    exp_done_q.push_back('{err, code, area, 16'(lat)});
    done_seen = 1'b0;
    @(posedge clk);
    #1;
    i_start_con   = 1'b1;
    im_base_addr  = base;
    im_area_en    = mask;
    i_stop_on_err = stop;
    start_cyc     = cyc;
    @(posedge clk);
    #1;
    i_start_con   = 1'b0;
    im_base_addr  = ~base;
    im_area_en    = ~mask;
    i_stop_on_err = ~stop;
    @(negedge clk);
    chk("busy_after_start", 64'(o_busy), 64'd1);
    chk("base_captured", 64'(om_base_addr), 64'(base));
    chk("code_cleared", 64'(om_err_code), 64'd0);
    // A start request while the sequence runs must be ignored.
    @(posedge clk);
    #1;
    i_start_con  = 1'b1;
    im_base_addr = base ^ 12'hA5A;
    @(posedge clk);
    #1;
    i_start_con  = 1'b0;
    budget = 0;
    while (!done_seen && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("starts_left", 64'(exp_start_q.size()), 64'd0);
    if (!done_seen) begin
      exp_start_q.delete();
      exp_done_q.delete();
    end
    @(negedge clk);
    chk("busy_after_done", 64'(o_busy), 64'd0);
    chk("done_one_cycle", 64'(o_done_con), 64'd0);
    chk("code_holds", 64'(om_err_code), 64'(code));
    chk("area_holds", 64'(om_err_area), 64'(area));
    chk("base_holds", 64'(om_base_addr), 64'(base));
  endtask

  initial begin : watchdog_guard
    #500000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin : stim
    n_vec         = 0;
    n_err         = 0;
    err_cfg       = '0;
    hang_cfg      = '0;
    done_seen     = 1'b0;
    i_start_con   = 1'b0;
    im_base_addr  = '0;
    im_area_en    = '0;
    i_stop_on_err = 1'b0;
    rst           = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done_con), 64'd0);
    chk("rst_error", 64'(o_error_con), 64'd0);
    chk("rst_code", 64'(om_err_code), 64'd0);
    chk("rst_area", 64'(om_err_area), 64'd0);
    chk("rst_start", 64'(om_start), 64'd0);
    chk("rst_base", 64'(om_base_addr), 64'd0);
    chk("rst_grant", 64'(om_grant), 64'd0);
    chk("rst_fram", 64'(om_fram_bus), 64'd0);
    chk("rst_cudb", 64'(om_cudb_bus), 64'd0);
    chk("rst_cddb", 64'(om_cddb_bus), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(3'b111, 1'b0, 12'h123, 3'b111, 1'b0, 2'd0, 3'd0, 41);
    run_seq(3'b101, 1'b0, 12'h456, 3'b101, 1'b0, 2'd0, 3'd0, 28);
    run_seq(3'b000, 1'b0, 12'h789, 3'b000, 1'b0, 2'd0, 3'd0, 3);
    run_seq(3'b010, 1'b0, 12'hABC, 3'b010, 1'b0, 2'd0, 3'd0, 16);
    run_seq(3'b100, 1'b0, 12'hDEF, 3'b100, 1'b0, 2'd0, 3'd0, 15);

    err_cfg = 3'b010;
    run_seq(3'b111, 1'b1, 12'h0F0, 3'b011, 1'b1, 2'd1, 3'd1, 28);
    run_seq(3'b111, 1'b0, 12'h0F1, 3'b111, 1'b1, 2'd1, 3'd1, 41);
    err_cfg = 3'b101;
    run_seq(3'b111, 1'b0, 12'h0F2, 3'b111, 1'b1, 2'd1, 3'd0, 41);
    err_cfg = '0;

`ifdef SCAN_SEQ_WDOG_EN
    hang_cfg = 3'b001;
    run_seq(3'b111, 1'b0, 12'h321, 3'b111, 1'b1, 2'd2, 3'd0, 47);
    run_seq(3'b111, 1'b1, 12'h322, 3'b001, 1'b1, 2'd2, 3'd0, 21);
    hang_cfg = '0;
`endif

    // Reset in the middle of area 1's wait.
    exp_start_q.push_back(0);
    exp_start_q.push_back(1);
    @(posedge clk);
    #1;
    i_start_con   = 1'b1;
    im_base_addr  = 12'h555;
    im_area_en    = 3'b111;
    i_stop_on_err = 1'b0;
    start_cyc     = cyc;
    @(posedge clk);
    #1;
    i_start_con = 1'b0;
    repeat (18) @(posedge clk);
    #2;
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    chk("pre_rst_grant", 64'(om_grant), 64'b010);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(om_grant), 64'd0);
    chk("mid_rst_fram", 64'(om_fram_bus), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_base", 64'(om_base_addr), 64'd0);
    chk("starts_before_rst", 64'(exp_start_q.size()), 64'd0);
    exp_start_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_done", 64'(o_done_con), 64'd0);
    run_seq(3'b111, 1'b0, 12'h777, 3'b111, 1'b0, 2'd0, 3'd0, 41);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_seq_arb.md
# scan_seq_arb

Parametrised area-scan sequencer and shared-bus arbiter for the console scan path. On a start request it runs up to N_AREA area-scan engines one after another, in index order, skipping areas that are not enabled. It routes exactly one engine's FRAM, CUDB and CDDB request buses to the shared ports, using a registered one-hot grant mux instead of an OR-merge. It also supervises each area with a watchdog and reports which area failed and why.

## Interface
- N_AREA, 3, number of area-scan engines (2..8)
- IDX_W, 3, width of the area index (must hold N_AREA-1)
- FRAM_W, 43, packed FRAM request width: {rden, wren, addr16, wr_dv, wdata8, wr_len16}
- CUDB_W, 24, packed CUDB request width: {wren, addr15, din8}
- CDDB_W, 24, packed CDDB request width: {wren, addr15, wdata8}
- TO_W, 20, watchdog counter width
- TIMEOUT_CYC, 20'hF_FFFF, per-area cycle limit

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_start_con  in  1  start pulse; sampled only in IDLE
- im_base_addr  in  12  base address, captured at start
- im_area_en  in  N_AREA  enable mask, captured at start
- i_stop_on_err  in  1  1 = abort the sequence on the first error; captured at start
- o_busy  out  1  high from the accepted start until the cycle of o_done_con
- o_done_con  out  1  one-cycle completion pulse
- o_error_con  out  1  error flag, valid in the o_done_con cycle
- om_err_code  out  2  0 none, 1 area error, 2 watchdog timeout
- om_err_area  out  IDX_W  index of the first failing area
- om_start  out  N_AREA  one-hot, one-cycle start pulse to the engines
- om_base_addr  out  12  captured base address, driven to all engines
- i_done  in  N_AREA  per-engine done
- i_error  in  N_AREA  per-engine error
- im_fram_req  in  N_AREA*FRAM_W  packed FRAM requests, area k at [k*FRAM_W +: FRAM_W]
- om_fram_bus  out  FRAM_W  granted FRAM request
- im_cudb_req  in  N_AREA*CUDB_W  packed CUDB requests
- om_cudb_bus  out  CUDB_W  granted CUDB request
- im_cddb_req  in  N_AREA*CDDB_W  packed CDDB requests
- om_cddb_bus  out  CDDB_W  granted CDDB request
- om_grant  out  N_AREA  one-hot grant, all zero when idle

## Operation
FSM states: IDLE, SELECT, START, WAIT, NEXT, DONE.

- **IDLE:** when i_start_con=1, capture the base address, enable mask and stop-on-error flag. Clear the error registers, set idx=0, go to SELECT.
- **SELECT:** priority-encode the lowest enabled index at or above idx.
  - Found: load idx and the grant, go to START.
  - None found: go to DONE.
- **START:** drive om_start[idx] for one cycle, clear the watchdog counter, go to WAIT.
- **WAIT:** only i_done[idx] and i_error[idx] are observed; all other bits are ignored.
  - i_error[idx]=1 (including the same cycle as i_done[idx]): record code 1 if no error is recorded yet.
  - Either bit high: go to NEXT.
  - Watchdog reaching TIMEOUT_CYC-1: record code 2, go to NEXT.
- **NEXT:** clear the grant. If an error is recorded and the stop-on-error flag is set, go to DONE. Otherwise increment idx and go to SELECT; if idx=N_AREA-1, go to DONE.
- **DONE:** pulse o_done_con, set o_error_con = (code≠0), go to IDLE.

Bus and error rules:
- om_*_bus equals the granted slice, and is zero when no grant is active.
- Only the first error is recorded; om_err_code and om_err_area hold until the next accepted start.
- i_start_con outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, grant 0.
- Reset asserted mid-sequence releases the bus and clears all outputs immediately; no done pulse is produced.
- Start i_start_con in cycle t: SELECT at t+1, grant active from t+2, om_start at t+2.
- Bus mux is combinational from the registered grant, so there is zero added latency from request to shared port.
- After i_done[idx] in cycle d: NEXT at d+1, grant low from d+2. There is at least one dead bus cycle between areas.
- Last area done in cycle d: o_done_con at d+3.
- im_area_en=0: o_done_con at t+3, o_error_con=0.
- The watchdog counter saturates and does not wrap.

## Configuration
- SCAN_SEQ_WDOG_EN defined: the watchdog counter and code 2 are built in.
- SCAN_SEQ_WDOG_EN undefined: no counter is built, WAIT exits only on done or error, and code 2 is never produced.

## Test plan
- N_AREA=3, mask 3'b111, each engine raises done 10 cycles after its start -> om_start pulses 001, 010, 100 in that order; o_done_con with o_error_con=0; om_grant never has two bits set.
- Mask 3'b101 -> area 1 is never started; each bus shows only area 0 or area 2 data while that area is granted and is zero otherwise.
- Area 1 raises error with done in the same cycle, i_stop_on_err=1 -> area 2 is never started; om_err_code=1, om_err_area=1.
- Same stimulus with i_stop_on_err=0 -> area 2 runs; the error code still reads 1 with area 1.
- SCAN_SEQ_WDOG_EN defined, TIMEOUT_CYC=16, area 0 never raises done -> move-on after 16 cycles; om_err_code=2, om_err_area=0.
- Drive rst low during WAIT of area 1 -> om_grant=0, om_fram_bus=0 and o_busy=0 immediately; a fresh start afterwards completes normally.
